result_uart_tx: RTL and testbench
=================================

// Module: result_uart_tx
// PURPOSE
//  Downstream stage of the benchmark output mux. It takes the 3-bit selector and the
//  8-bit selected result and serialises them onto a single UART-style pin, so
//  results can be logged off-chip through one io_out bit.
//  Each accepted sample becomes a 2-character frame: a header char {5'b10110, sel},
//  then the data char.
// PARAMETERS
//  CLKS_PER_BIT  4  clk cycles per serial bit, >=2; counter width $clog2(CLKS_PER_BIT)
//  STOP_BITS     1  stop bits per character, 1 or 2
// PORTS
//  clk         in   1  single clock, all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  in_valid    in   1  sample offered
//  in_ready    out  1  block can accept a sample this cycle
//  in_sel      in   3  output-mux selector that produced in_data
//  in_data     in   8  selected result byte
//  tx          out  1  serial line, idle high
//  busy        out  1  high from acceptance through last stop bit
//  frame_done  out  1  1-cycle pulse in final cycle of the data char's last stop bit
// BEHAVIOUR
//  - Reset values: tx=1, in_ready=0 while reset high, busy=0, frame_done=0,
//    state=IDLE, counters=0. in_ready=1 the first cycle after reset drops.
//  - Accept on posedge where in_valid && in_ready.
//    - Capture sel/data into regs; later input changes are ignored.
//    - in_ready=0 and busy=1 from the next cycle.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (char==0 ? START of data char : IDLE).
//  - Character format, each bit held exactly CLKS_PER_BIT cycles:
//    - start bit 0;
//    - 8 data bits, LSB first;
//    - optional parity bit;
//    - STOP_BITS stop bits of 1.
//  - Latency: tx goes low in the cycle after acceptance (cycle 1).
//  - Char 0 is header {5'b10110, sel}; char 1 is data. No idle gap between chars.
//  - Frame length: 2*(1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, P = 1 if parity built in, else 0.
//  - Completion: frame_done pulses in the last frame cycle. The next cycle is IDLE with
//    in_ready=1, busy=0, tx=1. Back-to-back samples have no extra gap.
//  - in_valid while busy: ignored, no queueing, no effect on tx.
//  - Reset mid-frame: frame aborts, next cycle tx=1 and all outputs at reset values.
//    A partial char is never resumed.
//  - Bit-cell counter counts 0..CLKS_PER_BIT-1. Bit index counts 0..7. Neither wraps
//    outside its state.
// CONFIGURATION
//  RESULT_UART_PARITY_EN
//  - Defined: after bit 7 of every char, send one even-parity bit (XOR of the 8 data
//    bits) for CLKS_PER_BIT cycles. Each char is 11+STOP_BITS-1 bits.
//  - Undefined: no PARITY state; STOP follows DATA directly.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1)
//  1. Hold reset 3 cycles, then release
//     -> during reset tx=1, busy=0, frame_done=0, in_ready=0;
//     -> in_ready=1 in the cycle after release.
//  2. Send sel=3'b101, data=8'hA5, no parity
//     -> decoded chars 8'hB5 then 8'hA5;
//     -> tx low cycles 1-4;
//     -> frame_done at cycle 80, in_ready=1 at cycle 81.
//  3. During test 2, drive in_valid with data=8'h3C at cycle 20
//     -> decoded chars unchanged (B5, A5);
//     -> in_ready stays 0 until cycle 81.
//  4. Assert reset at cycle 30, in the header data bits
//     -> tx=1 from cycle 31, busy=0, no frame_done;
//     -> after release, a new sample sel=0, data=8'h01 decodes as B0, 01.
//  5. With RESULT_UART_PARITY_EN, send sel=3'b101, data=8'hA5
//     -> header parity bit 1, data parity bit 0;
//     -> frame_done at cycle 88.
//  6. Hold in_valid high for two samples, 8'h00 then 8'hFF
//     -> second sample accepted in the cycle after first frame_done;
//     -> tx stays high for exactly that one cycle between frames.

Source files
------------

// File: rtl/result_uart_tx.sv
// Serialises an accepted {sel, data} sample as a header char {5'b10110, sel} followed by a data char.
// Latency: tx drops in the cycle after acceptance; frame is 2*(10+P+STOP_BITS-1)*CLKS_PER_BIT cycles.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored. Build option: RESULT_UART_PARITY_EN.
module result_uart_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_sel,
   input  logic [7:0] in_data,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef RESULT_UART_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic            stop_q, stop_d;
   logic            char_q, char_d;
   logic [2:0]      sel_q, sel_d;
   logic [7:0]      data_q, data_d;

   logic            cell_end;
   logic            last_stop;
   logic [7:0]      cur_char;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         char_q  <= 1'b0;
         sel_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         char_q  <= char_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
      end
   end

   assign cell_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));
   assign last_stop = (STOP_BITS == 1) || stop_q;
   assign cur_char  = char_q ? data_q : {5'b10110, sel_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      char_d  = char_q;
      sel_d   = sel_q;
      data_d  = data_q;

      // Every non-idle state times its bit cell the same way.
      if (state_q != S_IDLE) begin
         cnt_d = cell_end ? '0 : cnt_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               state_d = S_START;
               sel_d   = in_sel;
               data_d  = in_data;
               char_d  = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
               stop_d  = 1'b0;
            end
         end
         S_START: begin
            if (cell_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (cell_end) begin
               if (bit_q == 3'd7) begin
                  bit_d = '0;
`ifdef RESULT_UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef RESULT_UART_PARITY_EN
         S_PARITY: begin
            if (cell_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (cell_end) begin
               if (last_stop) begin
                  stop_d = 1'b0;
                  if (!char_q) begin
                     state_d = S_START;
                     char_d  = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     char_d  = 1'b0;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (state_q)
         S_START:  tx = 1'b0;
         S_DATA:   tx = cur_char[bit_q];
`ifdef RESULT_UART_PARITY_EN
         S_PARITY: tx = ^cur_char;
`endif
         default:  tx = 1'b1;
      endcase
   end

   assign in_ready   = (state_q == S_IDLE) && !reset;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_STOP) && char_q && cell_end && last_stop;

endmodule

// File: tb/tb_result_uart_tx.sv
// Randomised bench for result_uart_tx: line waveform and decoded chars against an arithmetic frame model.
module tb_result_uart_tx;
   localparam int CPB = 4;
   localparam int SB  = 1;
`ifdef RESULT_UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int CHB = 1 + 8 + P + SB;
   localparam int FL  = 2 * CHB * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] in_sel = '0;
   logic [7:0] in_data = '0;
   logic       in_ready, tx, busy, frame_done;

   int n_pass = 0;
   int n_total = 0;

   result_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_data(in_data), .tx(tx), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Line level expected in frame cycle c (1-based) from the character layout.
   function automatic logic exp_tx(input logic [2:0] s, input logic [7:0] d, input int c);
      int idx, ch, b;
      logic [7:0] v;
      idx = (c - 1) / CPB;
      ch  = idx / CHB;
      b   = idx % CHB;
      v   = (ch == 0) ? {5'b10110, s} : d;
      if (b == 0) return 1'b0;
      if (b <= 8) return v[b-1];
      if (P == 1 && b == 9) return ^v;
      return 1'b1;
   endfunction

   task automatic accept(input logic [2:0] s, input logic [7:0] d);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("accept_ready", in_ready, 1);
      in_valid = 1'b1;
      in_sel   = s;
      in_data  = d;
      @(posedge clk);
   endtask

   task automatic watch_frame(input logic [2:0] s, input logic [7:0] d, input int inj,
                              input bit hold, input logic [7:0] hold_d);
      int wave_err, ctl_err, done_at, done_n, idx, ch, b;
      logic [7:0] dec [2];
      wave_err = 0; ctl_err = 0; done_at = -1; done_n = 0;
      dec[0] = '0; dec[1] = '0;
      for (int c = 1; c <= FL; c++) begin
         @(negedge clk);
         if (c == 1) begin
            if (hold) in_data = hold_d;
            else in_valid = 1'b0;
         end
         if (c == inj) begin
            in_valid = 1'b1;
            in_sel   = 3'd2;
            in_data  = 8'h3C;
         end
         if (c == inj + 1) in_valid = 1'b0;
         if (tx !== exp_tx(s, d, c)) wave_err++;
         if (busy !== 1'b1 || in_ready !== 1'b0) ctl_err++;
         if (frame_done === 1'b1) begin
            done_n++;
            if (done_at < 0) done_at = c;
         end
         // Receiver-style mid-cell sampling of the data bits.
         if ((c - 1) % CPB == CPB / 2) begin
            idx = (c - 1) / CPB;
            ch  = idx / CHB;
            b   = idx % CHB;
            if (b >= 1 && b <= 8) dec[ch][b-1] = tx;
         end
      end
      chk("tx_wave_errs", wave_err, 0);
      chk("hdr_char", dec[0], {5'b10110, s});
      chk("data_char", dec[1], d);
      chk("ready_busy_errs", ctl_err, 0);
      chk("done_cycle", done_at, FL);
      chk("done_count", done_n, 1);
   endtask

   task automatic post_check();
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", frame_done, 0);
   endtask

   initial begin
      int wave_err, done_n, inj;
      logic [2:0] s;
      logic [7:0] d;

      // Reset held three cycles.
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_ready", in_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);

      // Directed frame with a stray sample offered mid-frame.
      accept(3'b101, 8'hA5);
      watch_frame(3'b101, 8'hA5, 20, 1'b0, 8'h00);
      post_check();

      // Reset in the header data bits.
      accept(3'b101, 8'hA5);
      wave_err = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
         if (tx !== exp_tx(3'b101, 8'hA5, c)) wave_err++;
         if (c == 30) reset = 1'b1;
      end
      chk("pre_abort_wave", wave_err, 0);
      @(negedge clk);
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", frame_done, 0);
      chk("abort_ready", in_ready, 0);
      reset = 1'b0;
      done_n = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (frame_done !== 1'b0 || tx !== 1'b1) done_n++;
      end
      chk("no_resume", done_n, 0);
      accept(3'b000, 8'h01);
      watch_frame(3'b000, 8'h01, -1, 1'b0, 8'h00);
      post_check();

      // Back-to-back samples with in_valid held high.
      accept(3'b011, 8'h00);
      watch_frame(3'b011, 8'h00, -1, 1'b1, 8'hFF);
      post_check();
      @(posedge clk);
      watch_frame(3'b011, 8'hFF, -1, 1'b0, 8'h00);
      post_check();

      // Randomised samples, some with spurious in_valid while busy.
      for (int i = 0; i < 8; i++) begin
         s = 3'($urandom_range(0, 7));
         d = 8'($urandom_range(0, 255));
         inj = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(2, FL - 2));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         accept(s, d);
         watch_frame(s, d, inj, 1'b0, 8'h00);
         post_check();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
